// File: rtl/round_sequencer_if.sv
// round_sequencer_if: player buttons, countdown handshake and game status bundle.
interface round_sequencer_if;
  logic       start_btn;
  logic       stop_btn;
  logic [6:0] cd_current;
  logic       cd_win;
  logic       cd_lose;
  logic       cd_reset;
  logic       cd_stop;
  logic [6:0] cd_from;
  logic [3:0] round;
  logic [7:0] score;
  logic [1:0] lives;
  logic       result_valid;
  logic [1:0] result;
  logic [6:0] last_value;
  logic       game_over;
  logic       busy;
  modport master (
    input  start_btn, stop_btn, cd_current, cd_win, cd_lose,
    output cd_reset, cd_stop, cd_from, round, score, lives,
           result_valid, result, last_value, game_over, busy
  );
  modport slave (
    output start_btn, stop_btn, cd_current, cd_win, cd_lose,
    input  cd_reset, cd_stop, cd_from, round, score, lives,
           result_valid, result, last_value, game_over, busy
  );
endinterface

// File: rtl/round_sequencer.sv
// round_sequencer: game-round controller driving a countdown and tracking score/lives.
module round_sequencer #(
  parameter logic [6:0] FROM_INIT  = 7'd10,
  parameter logic [6:0] FROM_STEP  = 7'd2,
  parameter logic [6:0] FROM_MAX   = 7'd99,
  parameter logic [1:0] LIVES_INIT = 2'd3,
  parameter logic [3:0] ROUNDS     = 4'd8,
  parameter logic [2:0] RESULT_TMO = 3'd4
) (
  input logic clk,
  input logic reset,
  round_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, ARM, RUN, WAIT, SCORE, OVER} state_t;
  state_t state, state_n;
  logic start_q, stop_q;
  logic [2:0] wait_cnt;
  logic [1:0] verdict;
  logic [7:0] sum;
  logic start_edge, stop_edge, tmo, last_round;
  assign start_edge = bus.start_btn & ~start_q;
  assign stop_edge  = bus.stop_btn & ~stop_q;
  assign tmo        = wait_cnt == RESULT_TMO - 3'd1;
  assign sum        = {1'b0, bus.cd_from} + {1'b0, FROM_STEP};
  // in SCORE, result already holds this round's verdict
  assign last_round = (bus.result != 2'b01 && bus.lives == 2'd1) || bus.round == ROUNDS;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    verdict = 2'b00;
    case (state)
      IDLE, OVER: state_n = start_edge ? ARM : state;
      ARM:        state_n = RUN;
      RUN: begin
        verdict = bus.cd_lose ? 2'b10 : 2'b00;
        state_n = bus.cd_lose ? SCORE : stop_edge ? WAIT : RUN;
      end
      WAIT: begin
        verdict = bus.cd_win ? 2'b01 : bus.cd_lose ? 2'b10 : tmo ? 2'b11 : 2'b00;
        state_n = verdict != 2'b00 ? SCORE : WAIT;
      end
      SCORE:      state_n = last_round ? OVER : ARM;
      default:    state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.busy      = state inside {ARM, RUN, WAIT, SCORE};
    bus.game_over = state == OVER;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q          <= 1'b1;
      stop_q           <= 1'b1;
      wait_cnt         <= 3'd0;
      bus.cd_reset     <= 1'b0;
      bus.cd_stop      <= 1'b0;
      bus.cd_from      <= FROM_INIT;
      bus.round        <= 4'd0;
      bus.score        <= 8'd0;
      bus.lives        <= LIVES_INIT;
      bus.result       <= 2'b00;
      bus.result_valid <= 1'b0;
      bus.last_value   <= 7'd0;
    end else begin
      start_q          <= bus.start_btn;
      stop_q           <= bus.stop_btn;
      wait_cnt         <= state == WAIT ? wait_cnt + 3'd1 : 3'd0;
      bus.cd_reset     <= state_n == ARM;
      bus.cd_stop      <= state == RUN && state_n == WAIT;
      bus.result_valid <= state_n == SCORE;
      if ((state == IDLE || state == OVER) && start_edge) begin
        bus.score   <= 8'd0;
        bus.lives   <= LIVES_INIT;
        bus.round   <= 4'd1;
        bus.cd_from <= FROM_INIT;
        bus.result  <= 2'b00;
      end
      if (state_n == SCORE) begin
        bus.result     <= verdict;
        bus.last_value <= bus.cd_current;
      end
      if (state == SCORE) begin
        if (bus.result == 2'b01) begin
          bus.score   <= bus.score == 8'hff ? 8'hff : bus.score + 8'd1;
          bus.cd_from <= sum > {1'b0, FROM_MAX} ? FROM_MAX : sum[6:0];
        end else
          bus.lives <= bus.lives - 2'd1;
        if (!last_round)
          bus.round <= bus.round + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed and random games checked against a round-level game model.
module tb_round_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  round_sequencer_if b0();
  round_sequencer_if b1();
  assign b1.start_btn  = b0.start_btn;
  assign b1.stop_btn   = b0.stop_btn;
  assign b1.cd_current = b0.cd_current;
  assign b1.cd_win     = b0.cd_win;
  assign b1.cd_lose    = b0.cd_lose;
  round_sequencer dut0 (.clk(clk), .reset(reset), .bus(b0.master));
  round_sequencer #(.FROM_INIT(7'd95)) dut1 (.clk(clk), .reset(reset), .bus(b1.master));
  int n_assert = 0, n_fail = 0;
  int m_score, m_lives, m_round, m_from0, m_from1, m_result;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_counters();
    chk("round", b0.round, m_round);
    chk("round_b1", b1.round, m_round);
    chk("score", b0.score, m_score);
    chk("lives", b0.lives, m_lives);
    chk("cd_from", b0.cd_from, m_from0);
    chk("cd_from_b1", b1.cd_from, m_from1);
    chk("result", b0.result, m_result);
  endtask
  task automatic chk_reset_state();
    chk("rst_cd_reset", b0.cd_reset, 0);
    chk("rst_cd_stop", b0.cd_stop, 0);
    chk("rst_cd_from", b0.cd_from, 10);
    chk("rst_cd_from_b1", b1.cd_from, 95);
    chk("rst_round", b0.round, 0);
    chk("rst_score", b0.score, 0);
    chk("rst_lives", b0.lives, 3);
    chk("rst_result", b0.result, 0);
    chk("rst_result_valid", b0.result_valid, 0);
    chk("rst_last_value", b0.last_value, 0);
    chk("rst_game_over", b0.game_over, 0);
    chk("rst_busy", b0.busy, 0);
  endtask
  task automatic check_arm();
    chk("arm_cd_reset", b0.cd_reset, 1);
    chk("arm_cd_stop", b0.cd_stop, 0);
    chk("arm_busy", b0.busy, 1);
    chk_counters();
    tick();
    chk("cd_reset_one_cycle", b0.cd_reset, 0);
  endtask
  task automatic new_game();
    b0.start_btn = 1'b1;
    tick();
    b0.start_btn = 1'b0;
    m_score = 0; m_lives = 3; m_round = 1; m_from0 = 10; m_from1 = 95; m_result = 0;
    check_arm();
  endtask
  // kind: 0 win after stop, 1 lose after stop, 2 timeout, 3 lose while running
  task automatic play_round(input int kind, input int pre, input int d, input bit both, output bit over);
    logic [6:0] exp_last;
    repeat (pre) begin
      b0.start_btn = 1'($urandom_range(0, 1));
      b0.cd_current = 7'($urandom);
      tick();
      chk("run_quiet", {b0.cd_reset, b0.cd_stop, b0.result_valid}, 0);
    end
    b0.start_btn = 1'b0;
    b0.cd_current = 7'($urandom);
    exp_last = b0.cd_current;
    if (kind == 3) begin
      b0.cd_lose = 1'b1;
      b0.stop_btn = both;
    end else
      b0.stop_btn = 1'b1;
    tick();
    b0.cd_lose = 1'b0;
    b0.stop_btn = 1'b0;
    if (kind != 3) begin
      chk("cd_stop_pulse", b0.cd_stop, 1);
      chk("wait_busy", b0.busy, 1);
      repeat (kind == 2 ? 3 : d) begin
        b0.cd_current = 7'($urandom);
        tick();
        chk("wait_quiet", {b0.cd_stop, b0.result_valid}, 0);
      end
      b0.cd_current = 7'($urandom);
      exp_last = b0.cd_current;
      b0.cd_win = kind == 0;
      b0.cd_lose = kind == 1;
      tick();
      b0.cd_win = 1'b0;
      b0.cd_lose = 1'b0;
    end else
      chk("no_cd_stop_on_lose", b0.cd_stop, 0);
    m_result = kind == 0 ? 1 : kind == 2 ? 3 : 2;
    chk("result_valid", b0.result_valid, 1);
    chk("verdict", b0.result, m_result);
    chk("last_value", b0.last_value, exp_last);
    if (kind == 0) begin
      m_score = m_score < 255 ? m_score + 1 : 255;
      m_from0 = m_from0 + 2 > 99 ? 99 : m_from0 + 2;
      m_from1 = m_from1 + 2 > 99 ? 99 : m_from1 + 2;
    end else
      m_lives--;
    over = m_lives == 0 || m_round == 8;
    if (!over) m_round++;
    b0.cd_current = 7'($urandom);
    tick();
    chk("result_valid_one_cycle", b0.result_valid, 0);
    if (over) begin
      chk("game_over", b0.game_over, 1);
      chk("over_busy", b0.busy, 0);
      chk("over_cd_reset", b0.cd_reset, 0);
      chk_counters();
      b0.stop_btn = 1'b1;
      b0.cd_lose = 1'b1;
      tick();
      tick();
      b0.stop_btn = 1'b0;
      b0.cd_lose = 1'b0;
      chk("over_hold", b0.game_over, 1);
      chk_counters();
    end else
      check_arm();
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit over;
    b0.start_btn = 1'b0; b0.stop_btn = 1'b0; b0.cd_current = 7'd0;
    b0.cd_win = 1'b0; b0.cd_lose = 1'b0;
    repeat (3) tick();
    chk_reset_state();
    reset = 1'b0;
    tick();
    chk("idle_after_reset", b0.busy, 0);
    new_game();
    play_round(0, 1, 0, 1'b0, over);
    play_round(3, 0, 0, 1'b1, over);
    play_round(2, 2, 0, 1'b0, over);
    play_round(1, 0, 3, 1'b0, over);
    chk("three_losses_over", over, 1);
    chk("held_score", b0.score, 1);
    new_game();
    for (int r = 0; r < 8; r++) play_round(0, r % 3, r % 4, 1'b0, over);
    chk("eight_wins_over", over, 1);
    chk("clamp_99", b1.cd_from, 99);
    for (int g = 0; g < 6; g++) begin
      new_game();
      over = 1'b0;
      for (int r = 0; r < 8 && !over; r++)
        play_round($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), over);
      chk("random_game_over", over, 1);
    end
    new_game();
    b0.start_btn = 1'b1;
    b0.stop_btn = 1'b1;
    reset = 1'b1;
    tick();
    chk_reset_state();
    reset = 1'b0;
    tick();
    tick();
    chk("held_btn_no_start", b0.busy, 0);
    chk("held_btn_no_cd_reset", b0.cd_reset, 0);
    chk("held_btn_round", b0.round, 0);
    b0.start_btn = 1'b0;
    b0.stop_btn = 1'b0;
    tick();
    new_game();
    play_round(0, 0, 1, 1'b0, over);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter FROM_INIT, default 7'd10: countdown start value for round 1.
REQ-002 Parameter FROM_STEP, default 7'd2: added to cd_from after each win.
REQ-003 Parameter FROM_MAX, default 7'd99: ceiling for cd_from.
REQ-004 Parameter LIVES_INIT, default 2'd3: lives at game start.
REQ-005 Parameter ROUNDS, default 4'd8: rounds per game.
REQ-006 Parameter RESULT_TMO, default 3'd4: cycles allowed for the countdown verdict after cd_stop.
REQ-007 clk  in  1  single system clock; all logic on posedge clk.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start_btn  in  1  player start button, level, synchronous to clk.
REQ-010 stop_btn  in  1  player stop button, level, synchronous to clk.
REQ-011 cd_current  in  7  countdown current value; unused by control, latched for display.
REQ-012 cd_win  in  1  countdown win flag.
REQ-013 cd_lose  in  1  countdown lose flag.
REQ-014 cd_reset  out  1  one-cycle load/start pulse to the countdown.
REQ-015 cd_stop  out  1  one-cycle stop pulse to the countdown.
REQ-016 cd_from  out  7  countdown load value.
REQ-017 round  out  4  current round number, 1-based; 0 when idle.
REQ-018 score  out  8  wins this game.
REQ-019 lives  out  2  remaining lives.
REQ-020 result_valid  out  1  one-cycle pulse when a round verdict is recorded.
REQ-021 result  out  2  last verdict: 00 none, 01 win, 10 lose, 11 timeout; held until the next verdict.
REQ-022 last_value  out  7  cd_current sampled at the verdict.
REQ-023 game_over  out  1  high in state OVER.
REQ-024 busy  out  1  high in ARM, RUN, WAIT and SCORE.

Function
REQ-025 Button edges SHALL be btn & ~btn_q, with btn_q registered each cycle; edges SHALL be ignored in any state not listed as consuming them.
REQ-026 The FSM SHALL have states IDLE, ARM, RUN, WAIT, SCORE and OVER.
REQ-027 IDLE/OVER + start edge -> ARM; score<=0, lives<=LIVES_INIT, round<=1, cd_from<=FROM_INIT, result<=00, on the same edge.
REQ-028 ARM SHALL last exactly 1 cycle with cd_reset=1, then -> RUN.
REQ-029 In RUN, cd_lose=1 -> SCORE with verdict lose, taking priority over a same-cycle stop edge.
REQ-030 In RUN, a stop edge with cd_lose=0 -> WAIT, with cd_stop=1 for exactly the first WAIT cycle.
REQ-031 In WAIT, cd_win=1 -> SCORE (win); else cd_lose=1 -> SCORE (lose); if neither is seen within RESULT_TMO cycles of entering WAIT -> SCORE (timeout).
REQ-032 Entering SCORE SHALL latch result and last_value=cd_current, and result_valid SHALL pulse for that one SCORE cycle.
REQ-033 SCORE, win: score+1 saturating at 255; cd_from<=min(cd_from+FROM_STEP, FROM_MAX), computed 8-bit before clamping.
REQ-034 SCORE, lose or timeout: lives-1; cd_from unchanged.
REQ-035 SCORE -> OVER if the post-update lives==0 or round==ROUNDS; else round+1 and -> ARM.
REQ-036 OVER SHALL hold all counters and result until a start edge.
REQ-037 cd_reset and cd_stop SHALL be registered outputs and never high in the same cycle.

Reset
REQ-038 While reset=1: state=IDLE; cd_reset=0, cd_stop=0, cd_from=FROM_INIT, round=0, score=0, lives=LIVES_INIT, result=00, result_valid=0, last_value=0, game_over=0, busy=0.
REQ-039 While reset=1, btn_q SHALL load 1 so buttons held through reset produce no edge.
REQ-040 Reset SHALL override every state mid-round in the same cycle; no cd_reset or cd_stop pulse is issued.

Verification
REQ-041 Reset, start pulse -> cd_reset high exactly 1 cycle, cd_from=10, round=1, lives=3, busy=1.
REQ-042 In RUN, stop pulse, cd_win=1 one cycle later -> cd_stop 1 cycle, result=01, result_valid 1 cycle, score=1, cd_from=12, round=2, new cd_reset.
REQ-043 In RUN, cd_lose=1 and stop edge in the same cycle -> no cd_stop, result=10, lives=2.
REQ-044 Stop sent, cd_win/cd_lose held 0 -> after 4 WAIT cycles result=11, lives decrement.
REQ-045 Three losses -> game_over=1, busy=0, score held; a further start pulse restarts with score=0, lives=3, round=1.
REQ-046 Eight wins with FROM_INIT=95 -> cd_from clamps at 99, OVER after round 8; reset asserted mid-RUN -> all outputs at REQ-038 values on the next cycle.
